fp_comp_add: RTL and testbench

- Registered IEEE-754 floating-point adder for the IPU datapath.
- DOUBLE=0: the 64-bit word is a packed complex single-precision value (real [63:32], imag [31:0]); both lanes are added in parallel.
- DOUBLE=1: the 64-bit word is one double-precision real.
- One-cycle latency with a valid strobe.

---
 rtl/fp_comp_add.sv | 253 +++++++++++++++++++++++++
 tb/tb_fp_comp_add.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fp_comp_add.sv
// fp_comp_add: registered IEEE-754 adder with one cycle of latency.
//   DOUBLE=0 : 64-bit word holds a packed complex binary32 value
//              (real [63:32], imag [31:0]); both lanes are added independently.
//   DOUBLE=1 : 64-bit word holds one binary64 value.
// Subnormal inputs are read as signed zero and sub-normal results flush to
// signed zero. Rounding is round-to-nearest, ties-to-even.
// Optional build macro COMP_ADD_FLAGS_EN adds a registered flags[2:0] output
// {invalid, overflow, inexact}.

module fp_comp_add_lane #(
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 23
) (
    input  logic [EW+MW:0] a,
    input  logic [EW+MW:0] b,
    output logic [EW+MW:0] sum
`ifdef COMP_ADD_FLAGS_EN
    ,
    output logic           inexact,
    output logic           overflow,
    output logic           invalid
`endif
);

    localparam int unsigned W   = EW + MW + 1;
    localparam int unsigned SW  = MW + 5;          // carry, hidden, fraction, G, R, S
    localparam int unsigned LZW = $clog2(SW + 1);

    localparam logic [EW-1:0]   EMAX  = '1;
    localparam logic [EW-1:0]   DMAX  = EW'(MW + 4);
    localparam logic [EW+1:0]   ONE_E = (EW+2)'(1);
    localparam logic [W-1:0]    QNAN  = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};

    // operand fields
    logic          s_a, s_b;
    logic [EW-1:0] e_a, e_b;
    logic [MW-1:0] f_a, f_b;
    logic [MW:0]   sig_a, sig_b;
    logic          nan_a, nan_b, inf_a, inf_b;
    logic          a_big;

    assign s_a   = a[W-1];
    assign s_b   = b[W-1];
    assign e_a   = a[W-2:MW];
    assign e_b   = b[W-2:MW];
    assign f_a   = a[MW-1:0];
    assign f_b   = b[MW-1:0];
    assign nan_a = (e_a == EMAX) && (f_a != '0);
    assign nan_b = (e_b == EMAX) && (f_b != '0);
    assign inf_a = (e_a == EMAX) && (f_a == '0);
    assign inf_b = (e_b == EMAX) && (f_b == '0);
    // exponent zero means zero here: the fraction of a subnormal is discarded
    assign sig_a = (e_a == '0) ? '0 : {1'b1, f_a};
    assign sig_b = (e_b == '0) ? '0 : {1'b1, f_b};
    assign a_big = {e_a, sig_a} >= {e_b, sig_b};

    // swap / align / add-or-subtract
    logic          s_l;
    logic [EW-1:0] e_l, e_s, d, d_c;
    logic [MW:0]   sig_l, sig_s;
    logic [MW+3:0] small_ext, shifted, mask, ones, aligned;
    logic          sticky, eff_sub;
    logic [SW-1:0] raw;

    // Larger magnitude goes first so the subtraction never goes negative.
    always_comb begin
        s_l       = a_big ? s_a   : s_b;
        e_l       = a_big ? e_a   : e_b;
        sig_l     = a_big ? sig_a : sig_b;
        e_s       = a_big ? e_b   : e_a;
        sig_s     = a_big ? sig_b : sig_a;
        d         = e_l - e_s;
        d_c       = (d > DMAX) ? DMAX : d;
        ones      = '1;
        small_ext = {sig_s, 3'b000};
        shifted   = small_ext >> d_c;
        mask      = ~(ones << d_c);
        sticky    = |(small_ext & mask);
        aligned   = {shifted[MW+3:1], shifted[0] | sticky};
        eff_sub   = s_a ^ s_b;
        raw       = eff_sub ? ({1'b0, sig_l, 3'b000} - {1'b0, aligned})
                            : ({1'b0, sig_l, 3'b000} + {1'b0, aligned});
    end

    // leading-zero count of the raw sum (SW when the sum is zero)
    logic [LZW-1:0] lz;
    logic           found;

    // Count zeros from the carry position downwards.
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < SW; i++) begin
            if (!found) begin
                if (raw[SW-1-i]) found = 1'b1;
                else             lz    = lz + 1'b1;
            end
        end
    end

    // normalise / round / special-case selection
    logic [SW-1:0] norm;
    logic [MW-1:0] mant;
    logic [MW:0]   mant_r;
    logic          g, st, rnd_up, is_zero;
    logic [EW+1:0] e_norm, e_rnd;
`ifdef COMP_ADD_FLAGS_EN
    logic          snan_a, snan_b;

    assign snan_a = nan_a && !f_a[MW-1];
    assign snan_b = nan_b && !f_b[MW-1];
`endif

    // Normalise so the leading one sits in the carry slot, then round and
    // pick the final encoding; specials take priority in listed order.
    always_comb begin
        norm    = raw << lz;
        is_zero = !norm[SW-1];
        mant    = norm[SW-2:4];
        g       = norm[3];
        st      = |norm[2:0];
        rnd_up  = g & (st | mant[0]);
        mant_r  = {1'b0, mant} + {{MW{1'b0}}, rnd_up};
        e_norm  = {2'b00, e_l} + ONE_E - (EW+2)'(lz);
        e_rnd   = e_norm + (EW+2)'(mant_r[MW]);
        sum     = '0;
`ifdef COMP_ADD_FLAGS_EN
        inexact  = 1'b0;
        overflow = 1'b0;
        invalid  = 1'b0;
`endif
        if (nan_a || nan_b) begin
            sum = QNAN;
`ifdef COMP_ADD_FLAGS_EN
            invalid = snan_a | snan_b;
`endif
        end else if (inf_a && inf_b && (s_a != s_b)) begin
            sum = QNAN;
`ifdef COMP_ADD_FLAGS_EN
            invalid = 1'b1;
`endif
        end else if (inf_a) begin
            sum = a;
        end else if (inf_b) begin
            sum = b;
        end else if (is_zero) begin
            // exact cancellation gives +0; like-signed zeros keep their sign
            sum = {eff_sub ? 1'b0 : s_a, {(W-1){1'b0}}};
        end else if (e_rnd[EW+1] || (e_rnd == '0)) begin
            sum = {s_l, {(W-1){1'b0}}};
`ifdef COMP_ADD_FLAGS_EN
            inexact = 1'b1;
`endif
        end else if (e_rnd >= {2'b00, EMAX}) begin
            sum = {s_l, EMAX, {MW{1'b0}}};
`ifdef COMP_ADD_FLAGS_EN
            overflow = 1'b1;
            inexact  = 1'b1;
`endif
        end else begin
            // on mantissa carry-out the low bits are already zero
            sum = {s_l, e_rnd[EW-1:0], mant_r[MW-1:0]};
`ifdef COMP_ADD_FLAGS_EN
            inexact = g | st;
`endif
        end
    end

endmodule

module fp_comp_add #(
    parameter int unsigned DOUBLE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    output logic [63:0] result
`ifdef COMP_ADD_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);

    logic [63:0] sum_c;
`ifdef COMP_ADD_FLAGS_EN
    logic [2:0]  flags_c;
`endif

    if (DOUBLE != 0) begin : g_dbl
        fp_comp_add_lane #(.EW(11), .MW(52)) u_lane (
            .a        (a),
            .b        (b),
            .sum      (sum_c)
`ifdef COMP_ADD_FLAGS_EN
            ,
            .inexact  (flags_c[0]),
            .overflow (flags_c[1]),
            .invalid  (flags_c[2])
`endif
        );
    end else begin : g_cplx
`ifdef COMP_ADD_FLAGS_EN
        logic [1:0] inx, ovf, inv;

        assign flags_c = {|inv, |ovf, |inx};
`endif
        fp_comp_add_lane #(.EW(8), .MW(23)) u_re (
            .a        (a[63:32]),
            .b        (b[63:32]),
            .sum      (sum_c[63:32])
`ifdef COMP_ADD_FLAGS_EN
            ,
            .inexact  (inx[1]),
            .overflow (ovf[1]),
            .invalid  (inv[1])
`endif
        );
        fp_comp_add_lane #(.EW(8), .MW(23)) u_im (
            .a        (a[31:0]),
            .b        (b[31:0]),
            .sum      (sum_c[31:0])
`ifdef COMP_ADD_FLAGS_EN
            ,
            .inexact  (inx[0]),
            .overflow (ovf[0]),
            .invalid  (inv[0])
`endif
        );
    end

    // Output register: capture the sum on accepted operations, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
`ifdef COMP_ADD_FLAGS_EN
            flags     <= '0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= sum_c;
`ifdef COMP_ADD_FLAGS_EN
                flags  <= flags_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_comp_add.sv
// Directed-vector bench for fp_comp_add: one complex-single instance and one
// double instance share the operand inputs; each vector checks one of them.

module tb_fp_comp_add;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a, b;
    logic        vld_s, vld_d;
    logic [63:0] res_s, res_d;
`ifdef COMP_ADD_FLAGS_EN
    logic [2:0]  flg_s, flg_d;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    fp_comp_add #(.DOUBLE(0)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (vld_s),
        .result    (res_s)
`ifdef COMP_ADD_FLAGS_EN
        ,
        .flags     (flg_s)
`endif
    );

    fp_comp_add #(.DOUBLE(1)) dut_d (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (vld_d),
        .result    (res_d)
`ifdef COMP_ADD_FLAGS_EN
        ,
        .flags     (flg_d)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // drive one operation between edges and sample just after the capturing edge
    task automatic issue(input logic [63:0] va, input logic [63:0] vb);
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic vec_s(input string tag, input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] exp);
        issue(va, vb);
        check(tag, res_s, exp);
        check({tag, "_vld"}, 64'(vld_s), 64'd1);
    endtask

    task automatic vec_d(input string tag, input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] exp);
        issue(va, vb);
        check(tag, res_d, exp);
        check({tag, "_vld"}, 64'(vld_d), 64'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #12;
        check("rst_res_s", res_s, 64'h0);
        check("rst_vld_s", 64'(vld_s), 64'h0);
        check("rst_res_d", res_d, 64'h0);
        check("rst_vld_d", 64'(vld_d), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // complex single
        vec_s("s_plus_zero", 64'h3FF00000_00000000, 64'h00000000_00000000, 64'h3FF00000_00000000);
        vec_s("s_two_cancel", 64'h3F800000_40000000, 64'h3F800000_C0000000, 64'h40000000_00000000);
        vec_s("s_specials", 64'h7F800000_7F7FFFFF, 64'hFF800000_7F7FFFFF, 64'h7FC00000_7F800000);
`ifdef COMP_ADD_FLAGS_EN
        check("s_specials_flags", 64'(flg_s), 64'd7);
`endif
        // 1+1.5=2.5 ; 1+(-0.25)=0.75
        vec_s("s_add_sub", 64'h3F800000_3F800000, 64'h3FC00000_BE800000, 64'h40200000_3F400000);
        // 1+2^-24 tie stays even ; (1+2^-23)+2^-24 tie rounds up to even
        vec_s("s_tie_even", 64'h3F800000_3F800001, 64'h33800000_33800000, 64'h3F800000_3F800002);
`ifdef COMP_ADD_FLAGS_EN
        check("s_tie_flags", 64'(flg_s), 64'd1);
`endif
        // (-0)+(-0)=-0 ; (+0)+(-0)=+0
        vec_s("s_zero_sign", 64'h80000000_00000000, 64'h80000000_80000000, 64'h80000000_00000000);
        // pi-pi=+0 ; 1+(-2)=-1 (sign of larger)
        vec_s("s_cancel_sign", 64'h40490FDB_3F800000, 64'hC0490FDB_C0000000, 64'h00000000_BF800000);
        // qNaN and sNaN inputs -> canonical qNaN
        vec_s("s_nan_in", 64'h7FC00001_7F800001, 64'h3F800000_3F800000, 64'h7FC00000_7FC00000);
`ifdef COMP_ADD_FLAGS_EN
        check("s_nan_flags", 64'(flg_s), 64'd4);
`endif
        // -Inf+1=-Inf ; subnormal treated as zero: 1+denorm=1
        vec_s("s_inf_denorm", 64'hFF800000_00000001, 64'h3F800000_3F800000, 64'hFF800000_3F800000);
        // 1.5*2^-126 - 2^-126 underflows to +0 ; 2^-126 + 2^-126 = 2^-125
        vec_s("s_underflow", 64'h00C00000_00800000, 64'h80800000_00800000, 64'h00000000_01000000);

        // double
        vec_d("d_one_one", 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000);
        vec_d("d_tie_even", 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000000);
        vec_d("d_inf_inf", 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000);
`ifdef COMP_ADD_FLAGS_EN
        check("d_inf_flags", 64'(flg_d), 64'd4);
`endif
        vec_d("d_overflow", 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000);
        vec_d("d_sub", 64'h3FF8000000000000, 64'hBFE0000000000000, 64'h3FF0000000000000);
        vec_d("d_cancel", 64'hBFF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000);

        // back-to-back complex singles, then an idle cycle
        vec_s("b2b_0", 64'h3F800000_40000000, 64'h3F800000_40000000, 64'h40000000_40800000);
        vec_s("b2b_1", 64'h40400000_3F800000, 64'h3F800000_BF000000, 64'h40800000_3F000000);
        vec_s("b2b_2", 64'hC0000000_41200000, 64'hBF800000_41200000, 64'hC0400000_41A00000);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 64'h3F800000_3F800000;
        b        = 64'h3F800000_3F800000;
        @(posedge clk);
        #1;
        check("idle_vld", 64'(vld_s), 64'd0);
        check("idle_hold", res_s, 64'hC0400000_41A00000);

        // asynchronous reset between edges while an operation is presented
        @(negedge clk);
        in_valid = 1'b1;
        a        = 64'h3F800000_3F800000;
        b        = 64'h3F800000_3F800000;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res", res_s, 64'h0);
        check("arst_vld", 64'(vld_s), 64'd0);
        check("arst_res_d", res_d, 64'h0);
        @(posedge clk);
        #1;
        check("arst_held", res_s, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a     = 64'h40000000_40400000;
        b     = 64'h40000000_3F800000;
        @(posedge clk);
        #1;
        check("post_rst_res", res_s, 64'h40800000_40800000);
        check("post_rst_vld", 64'(vld_s), 64'd1);

        @(negedge clk);
        in_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
